// File: rtl/dmem_responder_pkg.sv
// Shared constants for the data-memory responder.
// RISC-V load/store size codes and FSM state encoding.
package dmem_responder_pkg;

  localparam logic [2:0] FUNCT3_B  = 3'b000;
  localparam logic [2:0] FUNCT3_H  = 3'b001;
  localparam logic [2:0] FUNCT3_W  = 3'b010;
  localparam logic [2:0] FUNCT3_BU = 3'b100;
  localparam logic [2:0] FUNCT3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for loads and stores.
// Flags misaligned or illegal accesses and zeroes their effects.
module dmem_lane_align
  import dmem_responder_pkg::*;
(
  input  logic        i_we,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_err
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [3:0]  w_be;
  logic        w_misal;
  logic        w_illegal;

  assign w_byte = 8'(i_rword >> {i_addr_lo, 3'b000});
  assign w_half = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];

  always_comb begin
    w_be      = 4'b0000;
    o_wdata   = '0;
    o_rdata   = '0;
    w_misal   = 1'b0;
    w_illegal = 1'b0;
    case (i_funct3)
      FUNCT3_B, FUNCT3_BU: begin
        w_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = i_funct3[2] ? {24'h0, w_byte}
                              : {{24{w_byte[7]}}, w_byte};
      end
      FUNCT3_H, FUNCT3_HU: begin
        w_misal = i_addr_lo[0];
        w_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = i_funct3[2] ? {16'h0, w_half}
                              : {{16{w_half[15]}}, w_half};
      end
      FUNCT3_W: begin
        w_misal = (i_addr_lo != 2'b00);
        w_be    = 4'b1111;
        o_wdata = i_wdata;
        o_rdata = i_rword;
      end
      default: w_illegal = 1'b1;
    endcase
    // unsigned codes only exist for loads
    o_err = w_misal | w_illegal | (i_we & i_funct3[2]);
    if (o_err || i_we) o_rdata = '0;
    o_be = (i_we && !o_err) ? w_be : 4'b0000;
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-stage data RAM responder: one request in flight,
// optional wait states, registered response via valid/ready.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int AW          = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam logic [3:0] WAIT_LD =
    (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t r_state;
  state_t w_next;

  logic [3:0]    r_cnt;
  logic          r_we;
  logic [AW+1:0] r_addr;
  logic [2:0]    r_funct3;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata;
  logic          r_err;
  logic [31:0]   r_mem [DEPTH];

  logic          w_accept;
  logic          w_access;
  logic          w_src_we;
  logic [AW+1:0] w_src_addr;
  logic [2:0]    w_src_funct3;
  logic [31:0]   w_src_wdata;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_rword;
  logic [3:0]    w_be;
  logic [31:0]   w_al_wdata;
  logic [31:0]   w_al_rdata;
  logic          w_al_err;
  logic          w_unused_addr;

  assign w_unused_addr = ^req_addr[31:AW+2];

  assign req_ready = (r_state == ST_IDLE);
  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

  assign w_accept = req_valid & req_ready;

  // zero-wait accesses happen on the accept edge itself
  assign w_src_we     = req_ready ? req_we            : r_we;
  assign w_src_addr   = req_ready ? req_addr[AW+1:0]  : r_addr;
  assign w_src_funct3 = req_ready ? req_funct3        : r_funct3;
  assign w_src_wdata  = req_ready ? req_wdata         : r_wdata;

  assign w_idx   = w_src_addr[AW+1:2];
  assign w_rword = r_mem[w_idx];

  dmem_lane_align u_align (
    .i_we      (w_src_we),
    .i_funct3  (w_src_funct3),
    .i_addr_lo (w_src_addr[1:0]),
    .i_wdata   (w_src_wdata),
    .i_rword   (w_rword),
    .o_be      (w_be),
    .o_wdata   (w_al_wdata),
    .o_rdata   (w_al_rdata),
    .o_err     (w_al_err)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:
        if (w_accept)
          w_next = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT:
        if (r_cnt == 4'd0) w_next = ST_RESP;
      ST_RESP:
        if (rsp_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_access = (w_next == ST_RESP) && (r_state != ST_RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept)
        r_cnt <= WAIT_LD;
      else if (r_state == ST_WAIT && r_cnt != 4'd0)
        r_cnt <= r_cnt - 4'd1;
      if (w_access) begin
        r_rdata <= w_al_rdata;
        r_err   <= w_al_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we     <= req_we;
      r_addr   <= req_addr[AW+1:0];
      r_funct3 <= req_funct3;
      r_wdata  <= req_wdata;
    end
  end

  // RAM is not reset; an access abandoned by reset never writes
  always_ff @(posedge clk) begin
    if (!rst && w_access) begin
      for (int i = 0; i < 4; i++)
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_al_wdata[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: two responders (0 and 3 wait states) driven
// with directed and random traffic against a byte-array model.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic [1:0]  rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_we;
  logic [31:0] req_addr [2];
  logic [2:0]  req_funct3 [2];
  logic [31:0] req_wdata [2];
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_rdata [2];
  logic [1:0]  rsp_err;

  int checks = 0;
  int errors = 0;
  int rmode [2];

  logic [7:0]  mm [2][4096];
  logic [32:0] q0 [$];
  logic [32:0] q1 [$];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(1024), .AW(10), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .rst(rst[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]),
    .req_funct3(req_funct3[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  dmem_responder #(.DEPTH(1024), .AW(10), .WAIT_CYCLES(3)) u1 (
    .clk(clk), .rst(rst[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]),
    .req_funct3(req_funct3[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  // Byte-addressed model; addresses alias modulo 4 KiB
  function automatic logic [32:0] ref_access(
    input int d, input logic we, input logic [31:0] a,
    input logic [2:0] f3, input logic [31:0] wd);
    int sz;
    int base;
    logic [31:0] v;
    case (f3)
      3'b000, 3'b100: sz = 1;
      3'b001, 3'b101: sz = 2;
      3'b010:         sz = 4;
      default:        sz = 0;
    endcase
    base = int'(a[11:0]);
    if (sz == 0 || (we && f3[2]) || (base % sz) != 0)
      return {1'b1, 32'h0};
    if (we) begin
      for (int i = 0; i < sz; i++) mm[d][base+i] = wd[8*i +: 8];
      return 33'h0;
    end
    v = 32'h0;
    for (int i = 0; i < sz; i++) v[8*i +: 8] = mm[d][base+i];
    if (!f3[2] && sz < 4 && v[8*sz-1])
      for (int i = 8*sz; i < 32; i++) v[i] = 1'b1;
    return {1'b0, v};
  endfunction

  task automatic chk(input string nm, input logic [32:0] act,
                     input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input int d, input logic [32:0] e);
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // track=0: no model update, no expectation (abandoned request)
  // use_x=1: expect the given constant instead of the model result
  task automatic issue(input int d, input logic we,
                       input logic [31:0] a, input logic [2:0] f3,
                       input logic [31:0] wd, input bit track,
                       input bit use_x, input logic [32:0] xexp);
    int n;
    logic [32:0] e;
    n = 0;
    @(negedge clk);
    while (!req_ready[d] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[d]) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout dev %0d: req_ready 0 expected 1", d);
      return;
    end
    req_valid[d] = 1'b1;
    req_we[d] = we;
    req_addr[d] = a;
    req_funct3[d] = f3;
    req_wdata[d] = wd;
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
    req_wdata[d] = $urandom;
    if (track) begin
      e = ref_access(d, we, a, f3, wd);
      push(d, use_x ? xexp : e);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain: pending %0d/%0d expected 0",
               q0.size(), q1.size());
    end
  endtask

  always @(posedge clk) begin
    #1;
    for (int d = 0; d < 2; d++)
      case (rmode[d])
        1:       rsp_ready[d] = 1'b0;
        2:       rsp_ready[d] = 1'b1;
        default: rsp_ready[d] = 1'($urandom_range(0, 1));
      endcase
  end

  always @(negedge clk) begin
    logic [32:0] e;
    for (int d = 0; d < 2; d++) begin
      if (!rst[d] && rsp_valid[d] && rsp_ready[d]) begin
        checks++;
        if ((d == 0 ? q0.size() : q1.size()) == 0) begin
          errors++;
          $display("FAIL unexpected_rsp dev %0d: got %h expected none",
                   d, {rsp_err[d], rsp_rdata[d]});
        end else begin
          e = (d == 0) ? q0.pop_front() : q1.pop_front();
          if ({rsp_err[d], rsp_rdata[d]} !== e) begin
            errors++;
            $display("FAIL rsp dev %0d: got err=%b rdata=%h expected err=%b rdata=%h",
                     d, rsp_err[d], rsp_rdata[d], e[32], e[31:0]);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    int k;
    bit rr_bad;
    rst = 2'b11;
    req_valid = 2'b00;
    req_we = 2'b00;
    rsp_ready = 2'b00;
    rmode[0] = 0;
    rmode[1] = 0;
    for (int d = 0; d < 2; d++) begin
      req_addr[d] = '0;
      req_funct3[d] = '0;
      req_wdata[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 2'b00;
    for (int d = 0; d < 2; d++) begin
      chk("reset_req_ready", 33'(req_ready[d]), 33'd1);
      chk("reset_rsp_valid", 33'(rsp_valid[d]), 33'd0);
      chk("reset_rsp", {rsp_err[d], rsp_rdata[d]}, 33'h0);
    end

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 64; i++)
        issue(d, 1'b1, 32'(4*i), 3'b010, $urandom, 1, 0, 33'h0);

    // zero-wait directed sequence
    issue(0, 1'b1, 32'h10, 3'b010, 32'hDEADBEEF, 1, 1, 33'h0);
    chk("lat0_sw", 33'(rsp_valid[0]), 33'd1);
    issue(0, 1'b0, 32'h10, 3'b010, 0, 1, 1, {1'b0, 32'hDEADBEEF});
    chk("lat0_lw", 33'(rsp_valid[0]), 33'd1);
    issue(0, 1'b1, 32'h13, 3'b000, 32'h80, 1, 1, 33'h0);
    issue(0, 1'b0, 32'h13, 3'b000, 0, 1, 1, {1'b0, 32'hFFFFFF80});
    issue(0, 1'b0, 32'h13, 3'b100, 0, 1, 1, {1'b0, 32'h00000080});
    issue(0, 1'b0, 32'h10, 3'b010, 0, 1, 1, {1'b0, 32'h80ADBEEF});
    issue(0, 1'b1, 32'h12, 3'b001, 32'h1234, 1, 1, 33'h0);
    issue(0, 1'b0, 32'h12, 3'b101, 0, 1, 1, {1'b0, 32'h00001234});
    issue(0, 1'b0, 32'h11, 3'b010, 0, 1, 1, {1'b1, 32'h0});
    issue(0, 1'b1, 32'h21, 3'b001, 32'hFFFF, 1, 1, {1'b1, 32'h0});
    issue(0, 1'b0, 32'h20, 3'b010, 0, 1, 0, 33'h0);
    issue(0, 1'b0, 32'h1000, 3'b010, 0, 1, 0, 33'h0);
    issue(0, 1'b0, 32'h0, 3'b011, 0, 1, 1, {1'b1, 32'h0});
    issue(0, 1'b1, 32'h30, 3'b100, 32'h55, 1, 1, {1'b1, 32'h0});
    issue(0, 1'b0, 32'h30, 3'b010, 0, 1, 0, 33'h0);
    drain();

    // three wait states, response held off for five cycles
    rmode[1] = 1;
    issue(1, 1'b0, 32'h10, 3'b010, 0, 1, 0, 33'h0);
    k = 0;
    rr_bad = 1'b0;
    while (!rsp_valid[1] && k < 20) begin
      if (req_ready[1]) rr_bad = 1'b1;
      if (k == 1) begin
        req_valid[1] = 1'b1;
        req_we[1] = 1'b1;
        req_addr[1] = 32'h10;
        req_funct3[1] = 3'b010;
        req_wdata[1] = 32'hBAD0BAD0;
      end else begin
        req_valid[1] = 1'b0;
      end
      @(posedge clk);
      #1;
      k++;
    end
    req_valid[1] = 1'b0;
    chk("lat3_cycles", 33'(k + 1), 33'd4);
    held = rsp_rdata[1];
    for (int i = 0; i < 5; i++) begin
      if (req_ready[1] || !rsp_valid[1] || rsp_rdata[1] !== held)
        rr_bad = 1'b1;
      @(posedge clk);
      #1;
    end
    chk("wait_hold_stable", 33'(rr_bad), 33'd0);
    rmode[1] = 2;
    drain();
    rmode[1] = 0;
    issue(1, 1'b0, 32'h10, 3'b010, 0, 1, 0, 33'h0);

    // reset while a store is still waiting
    issue(1, 1'b1, 32'h40, 3'b010, 32'hAAAA5555, 0, 0, 33'h0);
    rst[1] = 1'b1;
    @(posedge clk);
    #1;
    rst[1] = 1'b0;
    chk("rst_wait_req_ready", 33'(req_ready[1]), 33'd1);
    chk("rst_wait_rsp_valid", 33'(rsp_valid[1]), 33'd0);
    chk("rst_wait_rsp", {rsp_err[1], rsp_rdata[1]}, 33'h0);
    issue(1, 1'b0, 32'h40, 3'b010, 0, 1, 0, 33'h0);
    drain();

    for (int n = 0; n < 150; n++)
      for (int d = 0; d < 2; d++)
        issue(d, 1'($urandom_range(0, 1)),
              {20'($urandom), 4'h0, 8'($urandom)},
              3'($urandom_range(0, 7)), $urandom, 1, 0, 33'h0);

    rmode[0] = 2;
    rmode[1] = 2;
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder at the far end of the memory-stage load/store interface.
- Accepts one load/store request at a time from the memory stage and applies RISC-V byte/half/word sizing and sign extension.
- Returns registered read data, or a write acknowledgement, through a valid/ready response handshake after a programmable number of wait states.
- Holds the word-organised data RAM array internally; the memory stage forwards its returned data to writeback.

Parameters:
- DEPTH, 1024, number of 32-bit words in the array (power of two).
- AW, 10, word-index width, log2(DEPTH).
- WAIT_CYCLES, 0, extra wait states between request acceptance and response (0..15).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address (ALU result).
- req_funct3  input  3  RISC-V size/sign code.
- req_wdata  input  32  store data, right-aligned (rs2).
- rsp_valid  output  1  response present.
- rsp_ready  input  1  memory stage consumes the response.
- rsp_rdata  output  32  load result, sized and extended; 0 for stores and errors.
- rsp_err  output  1  misaligned access or illegal funct3.

Behaviour:
- Reset: all outputs reset synchronously when rst=1 at a rising edge.
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
  - RAM contents are not cleared by reset.
- FSM states are IDLE, WAIT and RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, latch we/addr/funct3/wdata.
  - If WAIT_CYCLES=0, go to RESP; else load counter=WAIT_CYCLES-1 and go to WAIT.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle; on counter=0, go to RESP.
- Access edge: the edge entering RESP performs the RAM access and registers rsp_rdata/rsp_err.
  - Latency from the accept edge to rsp_valid=1 is WAIT_CYCLES+1 cycles.
- RESP:
  - rsp_valid=1, req_ready=0.
  - rsp_rdata and rsp_err are held stable until rsp_valid&rsp_ready.
  - That edge returns the FSM to IDLE and clears rsp_valid.
  - There is no bypass: a new request is accepted no earlier than the cycle after the handshake.
- Indexing: word index = addr[AW+1:2]. Upper address bits are ignored, so addresses alias modulo 4*DEPTH.
- funct3 encoding:
  - 000 = byte, signed.
  - 001 = half, signed.
  - 010 = word.
  - 100 = byte, unsigned (load only).
  - 101 = half, unsigned (load only).
- Loads:
  - Byte lane is selected by addr[1:0].
  - Half lane is selected by addr[1]: 0 = bits 15:0, 1 = bits 31:16.
  - The selected lane is sign- or zero-extended to 32 bits according to funct3.
- Stores:
  - Only the addressed lanes are written, using byte enables derived from size and addr[1:0].
  - The low byte/half of wdata is replicated into the selected lane.
  - Stores with funct3 100 or 101 are illegal.
- Errors set rsp_err=1, rsp_rdata=0 and suppress the RAM write. The response is still issued. Error conditions:
  - half access with addr[0]=1;
  - word access with addr[1:0]!=0;
  - funct3 011, 110 or 111;
  - store with funct3 100 or 101.
- Store response: rsp_rdata=0, rsp_err=0 on success.
- Back-to-back: a load following a store to the same address returns the newly written data.
- Reset mid-transaction: the transaction is abandoned.
  - A write whose access edge has already occurred persists.
  - A write still in WAIT is dropped.
- Request signals are ignored while req_ready=0.

Decomposition:
- Shared package constants:
  - FUNCT3_B=3'b000, FUNCT3_H=3'b001, FUNCT3_W=3'b010, FUNCT3_BU=3'b100, FUNCT3_HU=3'b101.
  - State encoding ST_IDLE, ST_WAIT, ST_RESP.
- One natural sub-module, dmem_lane_align (combinational):
  - Inputs: funct3, addr[1:0], wdata and RAM word.
  - Outputs: byte enables, aligned write data, extended load data and the misalign/illegal flag.
- FSM, wait counter and RAM array stay in the top module.

Test Plan:
- WAIT_CYCLES=0: SW 0xDEADBEEF @0x10, then LW @0x10 → rsp_valid 1 cycle after each accept; rdata=0xDEADBEEF, err=0.
- Sub-word:
  - SB 0x80 @0x13, then LB @0x13 → 0xFFFFFF80.
  - LBU @0x13 → 0x00000080.
  - LW @0x10 → 0x80ADBEEF.
  - SH 0x1234 @0x12, then LHU @0x12 → 0x00001234.
- Misalign: LW @0x11 → err=1, rdata=0. SH @0x21 → err=1, followed by LW @0x20 returning the prior value unchanged.
- WAIT_CYCLES=3 with rsp_ready held 0 for 5 cycles:
  - rsp_valid rises exactly 4 cycles after the accept edge.
  - rdata is stable while rsp_valid=1 and rsp_ready=0.
  - req_ready=0 throughout, and a req_valid pulse during this period is ignored.
- Reset in WAIT: SW 0xAAAA5555 @0x40 with WAIT_CYCLES=3, rst asserted 1 cycle after accept → outputs return to reset values; a later LW @0x40 returns the old contents.
- Aliasing/illegal:
  - With DEPTH=1024, LW @0x1000 returns the same data as @0x0.
  - funct3=011 → err=1.
  - Store with funct3=100 → err=1 and no write.
